// File: rtl/lzd_sched.sv
// lzd_sched: arbitrates two requesters onto a shared leading-zero detector and normalizes the operand; `LZD_SCHED_RR_EN selects round-robin over fixed priority
module lzd_sched #(
  parameter int TIMEOUT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lzd_en,
  output logic [7:0] lzd_in,
  input  logic [3:0] lzd_out,
  input  logic       lzd_done,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_norm,
  output logic [3:0] rsp_cnt,
  output logic       rsp_err,
  input  logic       rsp_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [3:0] WLAST = 4'(TIMEOUT - 1);
  state_t state, state_nx;
  logic [7:0] op;
  logic       id;
  logic [3:0] cnt;
  logic [3:0] wdog;
  logic       err;
  logic       gnt0;
  logic       gnt1;
  logic       grant;
  logic       tmo;
`ifdef LZD_SCHED_RR_EN
  logic last;
  assign gnt1 = req1_valid & (~req0_valid | ~last);
  // remember who won last so a contested grant alternates; reset favours requester 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (grant) last <= gnt1;
`else
  assign gnt1 = req1_valid & ~req0_valid;
`endif
  assign gnt0  = req0_valid & ~gnt1;
  assign grant = (state == IDLE) & (gnt0 | gnt1);
  assign tmo   = (state == WAIT) & ~lzd_done & (wdog == WLAST);
  // next-state sequencing of one operation at a time
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (lzd_done | tmo) ? RESP : WAIT;
      default: state_nx = rsp_ready ? IDLE : RESP;
    endcase
  end
  // state register plus operand latch, watchdog and result capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op    <= '0;
      id    <= 1'b0;
      cnt   <= '0;
      wdog  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        op <= gnt1 ? req1_data : req0_data;
        id <= gnt1;
      end
      if (state == ISSUE) wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 4'd1;
      if (state == WAIT && lzd_done) begin
        cnt <= (lzd_out > 4'd8) ? 4'd8 : lzd_out;
        err <= 1'b0;
      end else if (tmo) begin
        cnt <= 4'd8;
        err <= 1'b1;
      end
    end
  assign req0_ready = (state == IDLE) & gnt0;
  assign req1_ready = (state == IDLE) & gnt1;
  assign lzd_en     = (state == ISSUE);
  assign lzd_in     = (state == ISSUE || state == WAIT) ? op : 8'h00;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id;
  assign rsp_cnt    = cnt;
  assign rsp_err    = err;
  assign rsp_norm   = cnt[3] ? 8'h00 : (op << cnt[2:0]);
endmodule

// File: tb/tb_lzd_sched.sv
// tb_lzd_sched: table-driven, hand-sequenced and randomized checks of lzd_sched against a behavioural model
module tb_lzd_sched;
  localparam int TIMEOUT = 7;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       req0_valid = 0, req1_valid = 0;
  logic [7:0] req0_data = 0, req1_data = 0;
  logic       req0_ready, req1_ready;
  logic       lzd_en;
  logic [7:0] lzd_in;
  logic [3:0] lzd_out = 0;
  logic       lzd_done = 0;
  logic       rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_norm;
  logic [3:0] rsp_cnt;
  logic       rsp_ready = 0;
  int checks = 0;
  int errors = 0;

  lzd_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .lzd_en(lzd_en), .lzd_in(lzd_in), .lzd_out(lzd_out), .lzd_done(lzd_done),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_norm(rsp_norm),
    .rsp_cnt(rsp_cnt), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id; int data; int v; int d; int hold;
    int exp_cnt; int exp_norm; int exp_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, rsp_valid, 0);
    chk({name, "_en"}, lzd_en, 0);
    chk({name, "_in"}, lzd_in, 0);
    chk({name, "_rdy"}, {req0_ready, req1_ready}, 0);
    chk({name, "_rsp"}, {rsp_id, rsp_norm, rsp_cnt, rsp_err}, 0);
  endtask

  // one operation: id requests data, detector answers v on the d-th WAIT cycle (never if d>TIMEOUT)
  task automatic op(input int id, input int data, input int v, input int d, input int hold,
                    input int ec, input int en, input int ee);
    int n;
    int ew;
    ew = (d > TIMEOUT) ? TIMEOUT : d;
    @(negedge clk);
    if (id != 0) begin req1_valid = 1; req1_data = 8'(data); end
    else begin req0_valid = 1; req0_data = 8'(data); end
    #1;
    chk("grant_ready", id != 0 ? req1_ready : req0_ready, 1);
    chk("other_ready", id != 0 ? req0_ready : req1_ready, 0);
    chk("grant_no_en", lzd_en | rsp_valid, 0);
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    chk("issue_en", lzd_en, 1);
    chk("issue_in", lzd_in, data);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
      if (n == 1) begin
        chk("wait_en", lzd_en, 0);
        chk("wait_in", lzd_in, data);
      end
      lzd_done = (n == d);
      lzd_out = 4'(v);
    end
    lzd_done = 0;
    chk("wait_cycles", n, ew);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_cnt", rsp_cnt, ec);
    chk("rsp_norm", rsp_norm, en);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_in_zero", lzd_in, 0);
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1;
      req1_valid = 1;
      #1;
      chk("hold_rdy", {req0_ready, req1_ready, lzd_en}, 0);
      chk("hold_rsp", {rsp_valid, rsp_id, rsp_norm, rsp_cnt, rsp_err}, {1'b1, 1'(id), 8'(en), 4'(ec), 1'(ee)});
      @(negedge clk);
    end
    req0_valid = 0;
    req1_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("after_accept", {rsp_valid, lzd_en}, 0);
  endtask

  initial begin
    vec_t tbl[6];
    int ids[$];
    int gcyc[$];
    int cyc;
    int id, data, v, d, hold, ec, en, ee;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int ids[$];
    int gcyc[$];
    int cyc;
    int id, data, v, d, hold, ec, en, ee;
    tbl[0] = '{0, 8'h13, 3, 1, 0, 3, 8'h98, 0};
    tbl[1] = '{1, 8'h00, 8, 1, 0, 8, 8'h00, 0};
    tbl[2] = '{1, 8'h80, 0, 1, 0, 0, 8'h80, 0};
    tbl[3] = '{0, 8'h21, 12, 2, 1, 8, 8'h00, 0};
    tbl[4] = '{1, 8'h5A, 2, 99, 5, 8, 8'h00, 1};
    tbl[5] = '{0, 8'h07, 5, 7, 0, 5, 8'hE0, 0};
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    // both requesters valid continuously: four back-to-back operations
    @(negedge clk);
    req0_valid = 1; req1_valid = 1; req0_data = 8'h01; req1_data = 8'h02;
    lzd_done = 1; lzd_out = 4'd1; rsp_ready = 1;
    cyc = 0;
    while (ids.size() < 4 && cyc < 40) begin
      #1;
      chk("exclusive", int'(rsp_valid) + int'(lzd_en) + int'(req0_ready | req1_ready) <= 1, 1);
      if (req0_ready) begin ids.push_back(0); gcyc.push_back(cyc); end
      if (req1_ready) begin ids.push_back(1); gcyc.push_back(cyc); end
      @(negedge clk);
      cyc++;
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_count", ids.size(), 4);
    for (int i = 0; i < 4 && i < ids.size(); i++) begin
`ifdef LZD_SCHED_RR_EN
      chk("rr_id", ids[i], i % 2);
`else
      chk("fixed_id", ids[i], 0);
`endif
      if (i > 0) chk("rr_spacing", gcyc[i] - gcyc[i-1], 4);
    end
    repeat (4) @(negedge clk);
    rsp_ready = 0; lzd_done = 0;
    // directed vectors
    foreach (tbl[i])
      op(tbl[i].id, tbl[i].data, tbl[i].v, tbl[i].d, tbl[i].hold,
         tbl[i].exp_cnt, tbl[i].exp_norm, tbl[i].exp_err);
    // reset while waiting on the detector drops the operation
    @(negedge clk);
    req0_valid = 1; req0_data = 8'h33;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1;
    lzd_done = 1; lzd_out = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postreset_idle", {rsp_valid, lzd_en}, 0);
    end
    lzd_done = 0;
    // randomized operations against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      id = $urandom_range(0, 1);
      data = $urandom_range(0, 255);
      v = $urandom_range(0, 15);
      d = $urandom_range(1, TIMEOUT + 3);
      hold = $urandom_range(0, 3);
      ee = (d > TIMEOUT) ? 1 : 0;
      ec = ee ? 8 : (v > 8 ? 8 : v);
      en = (ec >= 8) ? 0 : ((data * (1 << ec)) % 256);
      op(id, data, v, d, hold, ec, en, ee);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lzd_sched.md
LZD_SCHED -- requirements
Module: lzd_sched

Interface
REQ-001 Parameter: TIMEOUT, default 7, number of WAIT cycles without lzd_done before the watchdog aborts the operation (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pending.
REQ-005 req0_data  input  8  requester 0 operand.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 has an operand pending.
REQ-008 req1_data  input  8  requester 1 operand.
REQ-009 req1_ready  output  1  requester 1 operand accepted this cycle.
REQ-010 lzd_en  output  1  enable to the shared leading-zero detector.
REQ-011 lzd_in  output  8  operand to the shared leading-zero detector.
REQ-012 lzd_out  input  4  leading-zero count from the detector (0..8).
REQ-013 lzd_done  input  1  detector result valid.
REQ-014 rsp_valid  output  1  normalized result available.
REQ-015 rsp_id  output  1  requester index owning the result.
REQ-016 rsp_norm  output  8  operand shifted left by rsp_cnt.
REQ-017 rsp_cnt  output  4  leading-zero count, 0..8.
REQ-018 rsp_err  output  1  result produced by watchdog, not by detector.
REQ-019 rsp_ready  input  1  consumer accepts result.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-021 IDLE: if any reqN_valid, grant one requester; its reqN_ready is high combinationally that cycle; other ready low; data and index latched; next state ISSUE.
REQ-022 reqN_ready is low in every state other than IDLE; requesters dropping valid before grant cause no action.
REQ-023 ISSUE: lzd_en high for exactly this one cycle; next state WAIT.
REQ-024 lzd_in shall equal the latched operand from ISSUE through WAIT, and 0 otherwise.
REQ-025 WAIT: lzd_en low; on lzd_done=1 capture lzd_out into rsp_cnt, clear rsp_err, next state RESP.
REQ-026 lzd_out values 9..15 shall saturate to 8.
REQ-027 WAIT watchdog: cycle counter cleared on entry; if lzd_done not seen after TIMEOUT cycles, rsp_cnt=8, rsp_err=1, next state RESP.
REQ-028 RESP: rsp_valid high, rsp_id/rsp_norm/rsp_cnt/rsp_err stable until rsp_ready sampled high; then IDLE.
REQ-029 rsp_norm = operand << rsp_cnt truncated to 8 bits; rsp_cnt=8 gives 0x00.
REQ-030 Minimum latency grant-to-rsp_valid: 3 cycles (IDLE grant, ISSUE, WAIT with done, RESP); best throughput one result per 4 cycles.
REQ-031 No grant in the cycle rsp_ready is accepted; earliest next grant is the following IDLE cycle.
REQ-032 rsp_valid, lzd_en, reqN_ready shall never be high in the same cycle.

Reset
REQ-033 rst_n low: state IDLE, all outputs 0, latched operand/index/count/watchdog cleared, arbitration pointer selects requester 0 next.
REQ-034 Reset mid-operation drops the in-flight operand with no response; operation restarts only on a new valid after release.

Configuration
REQ-035 Macro LZD_SCHED_RR_EN defined: round-robin arbitration; when both valid, grant the requester not granted last; pointer updates on every grant.
REQ-036 Macro LZD_SCHED_RR_EN undefined: fixed priority, requester 0 always wins when both valid; no pointer register.

Verification
REQ-037 req0 data 0x13, detector returns 3 one cycle after lzd_en -> rsp_id=0, rsp_cnt=3, rsp_norm=0x98, rsp_err=0, rsp_valid 3 cycles after grant.
REQ-038 req1 data 0x00, detector returns 8 -> rsp_cnt=8, rsp_norm=0x00; data 0x80 -> rsp_cnt=0, rsp_norm=0x80.
REQ-039 Both valid continuously, 4 operations -> with LZD_SCHED_RR_EN ids 0,1,0,1; without it ids 0,0,0,0.
REQ-040 lzd_done held low, TIMEOUT=7 -> rsp_valid after 7 WAIT cycles with rsp_cnt=8, rsp_err=1.
REQ-041 rsp_ready low 5 cycles in RESP -> outputs stable, no readies; rst_n low in WAIT -> all outputs 0, no response after release.
